// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the piso_tx serial transmitter.
// Frame length grows by one parity bit when PISO_PARITY_EN is defined.
package piso_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   function automatic int frame_len(input int width);
`ifdef PISO_PARITY_EN
      return width + 1;
`else
      return width;
`endif
   endfunction

   function automatic int cnt_width(input int flen);
      return $clog2(flen + 1);
   endfunction

endpackage

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: MSB-first, one bit per clk, with valid/last strobes.
// Optional even-parity trailer bit enabled by macro PISO_PARITY_EN.
//
// state | meaning
// IDLE  | no frame on the line, so/so_valid/so_last held at 0
// SHIFT | so carries a frame bit; cnt counts bits still to follow
module piso_tx
   import piso_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [WIDTH-1:0] pi,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             so,
   output logic             so_valid,
   output logic             so_last,
   output logic             busy
);

   localparam int FRAME_LEN = frame_len(WIDTH);
   localparam int CW        = cnt_width(FRAME_LEN);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             so_q, so_d;
   logic             so_valid_q, so_valid_d;
   logic             so_last_q, so_last_d;
   logic             accept;
`ifdef PISO_PARITY_EN
   logic             parity_q, parity_d;
`endif

   // A new word may be taken while the final bit of the current frame is on the line.
   assign load_ready = (state_q == IDLE) || (so_valid_q && so_last_q);
   assign accept     = load_valid && load_ready;

   always_comb begin
      state_d    = state_q;
      sreg_d     = sreg_q;
      cnt_d      = cnt_q;
      so_d       = so_q;
      so_valid_d = so_valid_q;
      so_last_d  = so_last_q;
`ifdef PISO_PARITY_EN
      parity_d   = parity_q;
`endif
      if (accept) begin
         state_d    = SHIFT;
         so_d       = pi[WIDTH-1];
         sreg_d     = pi << 1;
         cnt_d      = CW'(FRAME_LEN - 1);
         so_valid_d = 1'b1;
         so_last_d  = (FRAME_LEN == 1);
`ifdef PISO_PARITY_EN
         parity_d   = ^pi;
`endif
      end else if (state_q == SHIFT) begin
         if (cnt_q != '0) begin
`ifdef PISO_PARITY_EN
            so_d      = (cnt_q == CW'(1)) ? parity_q : sreg_q[WIDTH-1];
`else
            so_d      = sreg_q[WIDTH-1];
`endif
            sreg_d    = sreg_q << 1;
            cnt_d     = cnt_q - CW'(1);
            so_last_d = (cnt_q == CW'(1));
         end else begin
            state_d    = IDLE;
            so_d       = 1'b0;
            so_valid_d = 1'b0;
            so_last_d  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q    <= IDLE;
         sreg_q     <= '0;
         cnt_q      <= '0;
         so_q       <= 1'b0;
         so_valid_q <= 1'b0;
         so_last_q  <= 1'b0;
`ifdef PISO_PARITY_EN
         parity_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         sreg_q     <= sreg_d;
         cnt_q      <= cnt_d;
         so_q       <= so_d;
         so_valid_q <= so_valid_d;
         so_last_q  <= so_last_d;
`ifdef PISO_PARITY_EN
         parity_q   <= parity_d;
`endif
      end
   end

   assign so       = so_q;
   assign so_valid = so_valid_q;
   assign so_last  = so_last_q;
   assign busy     = so_valid_q;

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx (WIDTH=4): directed vector table, bit-queue model, loopback receiver.
module tb_piso_tx;

   localparam int W = 4;
`ifdef PISO_PARITY_EN
   localparam int FL = W + 1;
`else
   localparam int FL = W;
`endif

   logic         clk = 1'b0;
   logic         clr = 1'b1;
   logic [W-1:0] pi = '0;
   logic         load_valid = 1'b0;
   logic         load_ready, so, so_valid, so_last, busy;

   int checks = 0;
   int errors = 0;
   int accepted = 0;

   typedef struct {
      logic b;
      logic last;
   } sbit_t;

   sbit_t        exp_q[$];
   logic [W-1:0] word_q[$];
   logic [FL-1:0] rx = '0;

   typedef struct {
      logic         c;
      logic         lv;
      logic [W-1:0] p;
      logic [3:0]   exp; // {so, so_valid, so_last, load_ready}
   } vec_t;

   piso_tx #(.WIDTH(W)) dut (
      .clk(clk), .clr(clr), .pi(pi), .load_valid(load_valid),
      .load_ready(load_ready), .so(so), .so_valid(so_valid),
      .so_last(so_last), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
      end
   endtask

   // Model: a queue of bits still to appear on the line. The transmitter is
   // ready exactly when nothing is pending beyond the bit currently shown.
   task automatic step(input logic c, input logic lv, input logic [W-1:0] p);
      sbit_t e;
      logic  ev, es, el, er;
      logic [W-1:0] w;
      clr = c; load_valid = lv; pi = p;
      @(posedge clk);
      #1;
      if (c) begin
         exp_q.delete();
         word_q.delete();
         rx = '0;
      end else if (lv && exp_q.size() == 0) begin
         for (int i = 0; i < W; i++) exp_q.push_back('{p[W-1-i], (i == FL-1)});
`ifdef PISO_PARITY_EN
         exp_q.push_back('{^p, 1'b1});
`endif
         word_q.push_back(p);
         accepted++;
      end
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         ev = 1'b1; es = e.b; el = e.last;
      end else begin
         ev = 1'b0; es = 1'b0; el = 1'b0;
      end
      er = (exp_q.size() == 0);
      check("model_outputs", {3'b0, so, so_valid, so_last, load_ready, busy},
            {3'b0, es, ev, el, er, ev});
      if (so_valid) begin
         rx = {rx[FL-2:0], so};
         if (so_last) begin
            if (word_q.size() == 0) begin
               check("loopback_frame_expected", 8'd1, 8'd0);
            end else begin
               w = word_q.pop_front();
`ifdef PISO_PARITY_EN
               check("loopback_word", {4'b0, rx[W:1]}, {4'b0, w});
               check("loopback_parity", {7'b0, rx[0]}, {7'b0, ^w});
`else
               check("loopback_word", {4'b0, rx[W-1:0]}, {4'b0, w});
`endif
            end
         end
      end
   endtask

   vec_t vt[25];
   int   cyc;
   int   start_acc;

   initial begin
      vt[0]  = '{1'b1, 1'b0, 4'b0000, 4'b0001};
      vt[1]  = '{1'b1, 1'b0, 4'b0000, 4'b0001};
      vt[2]  = '{1'b0, 1'b0, 4'b0000, 4'b0001};
      vt[3]  = '{1'b0, 1'b1, 4'b1011, 4'b1100};
      vt[4]  = '{1'b0, 1'b1, 4'b1111, 4'b0100};
      vt[5]  = '{1'b0, 1'b1, 4'b1111, 4'b1100};
      vt[6]  = '{1'b0, 1'b0, 4'b0000, 4'b1111};
      vt[7]  = '{1'b0, 1'b0, 4'b0000, 4'b0001};
      vt[8]  = '{1'b0, 1'b1, 4'b1011, 4'b1100};
      vt[9]  = '{1'b0, 1'b1, 4'b0110, 4'b0100};
      vt[10] = '{1'b0, 1'b1, 4'b0110, 4'b1100};
      vt[11] = '{1'b0, 1'b1, 4'b0110, 4'b1111};
      vt[12] = '{1'b0, 1'b1, 4'b0110, 4'b0100};
      vt[13] = '{1'b0, 1'b0, 4'b0000, 4'b1100};
      vt[14] = '{1'b0, 1'b0, 4'b0000, 4'b1100};
      vt[15] = '{1'b0, 1'b0, 4'b0000, 4'b0111};
      vt[16] = '{1'b0, 1'b0, 4'b0000, 4'b0001};
      vt[17] = '{1'b0, 1'b1, 4'b1011, 4'b1100};
      vt[18] = '{1'b0, 1'b0, 4'b0000, 4'b0100};
      vt[19] = '{1'b1, 1'b1, 4'b0001, 4'b0001};
      vt[20] = '{1'b0, 1'b1, 4'b0001, 4'b0100};
      vt[21] = '{1'b0, 1'b0, 4'b0000, 4'b0100};
      vt[22] = '{1'b0, 1'b0, 4'b0000, 4'b0100};
      vt[23] = '{1'b0, 1'b0, 4'b0000, 4'b1111};
      vt[24] = '{1'b0, 1'b0, 4'b0000, 4'b0001};

`ifndef PISO_PARITY_EN
      for (int i = 0; i < 25; i++) begin
         step(vt[i].c, vt[i].lv, vt[i].p);
         check($sformatf("vector_%0d", i), {4'b0, so, so_valid, so_last, load_ready},
               {4'b0, vt[i].exp});
      end
`else
      step(1'b1, 1'b0, 4'b0000);
      step(1'b1, 1'b0, 4'b0000);
      step(1'b0, 1'b1, 4'b1011);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'b0000);
      step(1'b0, 1'b0, 4'b0000);
      check("parity_bit", {5'b0, so, so_valid, so_last}, 8'b0000_0111);
      step(1'b0, 1'b0, 4'b0000);
      check("parity_end_idle", {5'b0, so, so_valid, so_last}, 8'b0);
`endif

      // Random traffic: 16 accepted words with random valid gaps and held words.
      start_acc = accepted;
      cyc = 0;
      while ((accepted - start_acc) < 16 && cyc < 3000) begin
         step(1'b0, 1'($urandom_range(0, 1)), 4'($urandom));
         cyc++;
      end
      checks++;
      if ((accepted - start_acc) < 16) begin
         errors++;
         $display("FAIL random_budget: accepted %0d required 16", accepted - start_acc);
      end
      for (int i = 0; i < FL + 2; i++) step(1'b0, 1'b0, 4'b0000);
      check("drained_idle", {4'b0, so, so_valid, so_last, load_ready}, 8'b0000_0001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
